// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule: PC-1 on start, one PC-2 subkey per handshake
// Encrypt order walks C/D forward with left rotations; decrypt starts at K_ROUNDS and walks back.
module des_key_schedule #(
    parameter int ROUNDS = 16,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:64]   key_in,
    input  logic          decrypt,
    input  logic          start,
    input  logic          abort,
    output logic          idle,
    output logic          sk_valid,
    input  logic          sk_ready,
    output logic [1:48]   sk_out,
    output logic [RW-1:0] sk_round,
    output logic          done
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic int total_shift(input int n);
        int sum;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) sum += SH[i];
        end
        return sum;
    endfunction

    // Rotation that takes C0/D0 straight to C_ROUNDS/D_ROUNDS for decrypt order.
    localparam int TOT_MOD = total_shift(ROUNDS) % 28;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] res;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            res[6'(i + 1)] = k[7'(PC1[i])];
        end
        return res;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] res;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            res[6'(i + 1)] = cd[6'(PC2[i])];
        end
        return res;
    endfunction

    // 0-based lookup into the shift table for a run-time index.
    function automatic logic [4:0] sh_at(input int idx);
        logic [4:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (idx == i) res = 5'(SH[i]);
        end
        return res;
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic [4:0] n);
        return (x << n) | (x >> (5'd28 - n));
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic [4:0] n);
        return (x >> n) | (x << (5'd28 - n));
    endfunction

    typedef enum logic {ST_IDLE, ST_GEN} state_t;

    state_t        state, state_nxt;
    logic [1:28]   c, d;
    logic [RW-1:0] r;
    logic          mode;
    logic          load, step, finish;
    logic          last;
    logic [1:56]   pc1_cd;
    logic [4:0]    load_sh, step_sh;

    assign last    = (r == RW'(ROUNDS));
    assign pc1_cd  = pc1(key_in);
    assign load_sh = decrypt ? 5'(TOT_MOD) : 5'(SH[0]);
    assign step_sh = mode ? sh_at(ROUNDS - int'(r)) : sh_at(int'(r));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks both start and the handshake
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_GEN;
                    load      = 1'b1;
                end
            end
            ST_GEN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (sk_ready) begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                        finish    = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c    <= '0;
            d    <= '0;
            r    <= '0;
            mode <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                c    <= rotl(pc1_cd[1:28], load_sh);
                d    <= rotl(pc1_cd[29:56], load_sh);
                r    <= RW'(1);
                mode <= decrypt;
            end else if (step) begin
                r <= r + RW'(1);
                if (mode) begin
                    c <= rotr(c, step_sh);
                    d <= rotr(d, step_sh);
                end else begin
                    c <= rotl(c, step_sh);
                    d <= rotl(d, step_sh);
                end
            end
        end
    end

    assign idle     = (state == ST_IDLE);
    assign sk_valid = (state == ST_GEN);
    assign sk_out   = pc2({c, d});
    assign sk_round = sk_valid ? (mode ? (RW'(ROUNDS + 1) - r) : r) : '0;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES key-schedule generator. Accepts a 64-bit key, applies PC-1, then emits one 48-bit round subkey per accepted handshake, using rotations of C/D and PC-2. It generalises the standalone combinational PC-2 permutation in three ways: a configurable round count, encrypt or decrypt ordering, and valid/ready back-pressure. It sits between the key register and the DES round datapath in the SPI DES example.

Parameters:
ROUNDS, 16, number of subkeys generated per key; legal range 1..16; shift schedule truncated to the first ROUNDS entries.
RW, 5, width of round counter and sk_round port; must satisfy 2^RW > ROUNDS.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_in  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored by PC-1.
decrypt  in  1  sampled with start; 0 = K1..KROUNDS order, 1 = KROUNDS..K1 order.
start  in  1  begin schedule; honoured only when idle=1.
abort  in  1  synchronous cancel; returns to IDLE.
idle  out  1  high in IDLE.
sk_valid  out  1  subkey available.
sk_ready  in  1  consumer accepts subkey.
sk_out  out  [1:48]  current subkey = PC2(C||D), bit 1 = MSB.
sk_round  out  RW  1-based index of the key being presented (Kn index, not emission order).
done  out  1  one-cycle pulse after final subkey accepted.

Behaviour:
- Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. TOT = sum SH[1..ROUNDS]; TOT = 28 for ROUNDS = 16.
- Registers: C[1:28], D[1:28], round counter r (emission count), mode bit, state.
- States: IDLE, GEN.
- Reset (async, rst_n=0):
  - state = IDLE, C/D = 0, r = 0.
  - idle = 1, sk_valid = 0, done = 0, sk_out = PC2(0) = 0, sk_round = 0.
- IDLE & start:
  - PC1(key_in) splits into C0, D0; mode <= decrypt; r <= 1; go to GEN.
  - Encrypt load: C,D <= rotl(C0,SH[1]), rotl(D0,SH[1]).
  - Decrypt load: C,D <= rotl(C0,TOT mod 28), rotl(D0,TOT mod 28).
  - sk_valid rises the cycle after start. Latency start -> first valid = 1 clock.
- GEN outputs:
  - sk_valid = 1; sk_out = PC2(C||D), combinational from registers only.
  - sk_round = r (encrypt) or ROUNDS+1-r (decrypt).
  - sk_out and sk_round are held stable while sk_valid & !sk_ready.
- GEN & sk_valid & sk_ready & r < ROUNDS:
  - r <= r+1.
  - Encrypt: C,D <= rotl by SH[r+1].
  - Decrypt: C,D <= rotr by SH[ROUNDS+1-r].
  - Back-to-back acceptance gives 1 subkey per clock.
- GEN & accept & r == ROUNDS:
  - go to IDLE; done = 1 in the following cycle only; C/D retain their last value.
- start in GEN: ignored; no key or mode re-sample.
- start and done cycle coincide: legal, since IDLE is already entered; new schedule begins and done still pulses.
- abort:
  - Priority over start and the handshake; takes effect next edge.
  - state = IDLE, sk_valid = 0, no done pulse.
  - abort in IDLE has no effect.
- key_in and decrypt are only sampled on an accepted start; changes during GEN have no effect.
- Rotations are modulo 28 on each half independently.
- PC-1 and PC-2 are the FIPS 46-3 tables, 1-based MSB-first indexing.

Test Plan:
- Encrypt, key 133457799BBCDFF1, sk_ready = 1 -> 16 consecutive valid cycles; K1 = 1B02EFFC7072, K2 = 79AED9DBC9E5, K16 = CB3D8B0E17F5, sk_round 1..16; done one cycle after K16.
- Decrypt, same key -> first sk_out = CB3D8B0E17F5 with sk_round = 16, second = K15, last = 1B02EFFC7072 with sk_round = 1; full sequence equals reverse of encrypt.
- Back-pressure: random sk_ready toggling -> sk_out and sk_round stable while stalled; exactly 16 accepts; sequence identical to the first test.
- start during GEN with a different key -> ignored; abort at round 5 -> sk_valid low next cycle, idle = 1, no done; restart produces the full correct sequence.
- rst_n asserted mid-GEN (asynchronous, between edges) -> outputs immediately return to reset values; after release, start yields a correct K1.
- ROUNDS = 4 build, decrypt -> emits K4, K3, K2, K1 matching encrypt-mode values for the same key; done after the fourth accept.
